// File: rtl/note_recorder_pkg.sv
// Shared constants for the note-table datapath.
// FSM encoding, table geometry defaults and the silence code.
package note_recorder_pkg;

   // Recorder FSM encoding (legacy 2-bit constants).
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] WRITE   = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   // Geometry shared with the tone player and note-table RAM.
   localparam int DELAY_W_DEF = 19;
   localparam int ADDR_W_DEF  = 2;

   // A stored period of zero means "no tone in this slot".
   localparam int SILENCE = 0;

   // Counter width able to hold 0 .. n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/note_recorder_crossing_detector.sv
// Hysteresis polarity tracker with a rising-crossing pulse.
// Ports: sample/consume/clear in; pol register and rise pulse out.
module crossing_detector #(
   parameter int DATA_W = 32,
   parameter int THRESH = 1000000
) (
   input  logic                     rate_divider_clock,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] sample,
   input  logic                     consume,
   input  logic                     clear,
   output logic                     pol,
   output logic                     rise
);

   localparam logic signed [DATA_W-1:0] POS_T = DATA_W'(THRESH);
   localparam logic signed [DATA_W-1:0] NEG_T = -POS_T;

   logic pol_next;

   // Inside the dead band the previous polarity holds.
   always_comb begin
      pol_next = pol;
      if (sample > POS_T)
         pol_next = 1'b1;
      else if (sample < NEG_T)
         pol_next = 1'b0;
   end

   // Combinational so the owner sees the crossing on the
   // same sample that causes it.
   assign rise = consume & ~pol & pol_next;

   always_ff @(posedge rate_divider_clock) begin
      if (reset || clear)
         pol <= 1'b0;
      else if (consume)
         pol <= pol_next;
   end

endmodule

// File: rtl/note_recorder.sv
// Measures input tone period per note slot, writes the note table.
// Ports: clock/reset, start, audio FIFO handshake, RAM write port, busy/done.
module note_recorder
   import note_recorder_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int DELAY_W      = DELAY_W_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int SLOT_SAMPLES = 4800,
   parameter int THRESH       = 1000000
) (
   input  logic                     rate_divider_clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     audio_in_available,
   input  logic signed [DATA_W-1:0] left_channel_audio_in,
   output logic                     read_audio_in,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DELAY_W-1:0]       mem_wdata,
   output logic                     busy,
   output logic                     done
);

   localparam int SLOT_W = cnt_width(SLOT_SAMPLES);

   localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(SLOT_SAMPLES - 1);
   localparam logic [DELAY_W-1:0] P_MAX     = '1;
   localparam logic [DELAY_W-1:0] P_SILENT  = DELAY_W'(SILENCE);
   localparam logic [ADDR_W-1:0]  A_LAST    = '1;

   logic [1:0]         state;
   logic [SLOT_W-1:0]  slot_cnt;
   logic [DELAY_W-1:0] period_cnt;
   logic [DELAY_W-1:0] last_period;
   logic [DELAY_W-1:0] period_inc;
   logic [DELAY_W-1:0] last_next;
   logic               locked;
   logic               pol;
   logic               rise;
   logic               consume;
   logic               go;
   logic               slot_end;
   logic               st_idle;
   logic               st_cap;
   logic               st_wr;
   logic               unused_pol;

   assign st_idle = (state == IDLE) | (state == DONE);
   assign st_cap  = (state == CAPTURE);
   assign st_wr   = (state == WRITE);

   assign consume       = audio_in_available & st_cap;
   assign read_audio_in = consume;
   assign go            = start & st_idle;
   assign slot_end      = consume & (slot_cnt == SLOT_LAST);

   // Polarity itself is only needed by the detector.
   assign unused_pol = pol;

   // Sample count since the last crossing, saturating.
   assign period_inc = (period_cnt == P_MAX) ? P_MAX
                                             : period_cnt + 1'b1;

   // The first crossing only locks phase; later ones close a period.
   always_comb begin
      last_next = last_period;
      if (rise && locked)
         last_next = period_inc;
   end

   crossing_detector #(
      .DATA_W (DATA_W),
      .THRESH (THRESH)
   ) u_xdet (
      .rate_divider_clock (rate_divider_clock),
      .reset              (reset),
      .sample             (left_channel_audio_in),
      .consume            (consume),
      .clear              (go),
      .pol                (pol),
      .rise               (rise)
   );

   always_ff @(posedge rate_divider_clock) begin
      if (reset) begin
         state       <= IDLE;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= P_SILENT;
         busy        <= 1'b0;
         done        <= 1'b0;
         slot_cnt    <= '0;
         period_cnt  <= '0;
         last_period <= P_SILENT;
         locked      <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         unique case (1'b1)
            st_idle: begin
               if (go) begin
                  state       <= CAPTURE;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  mem_addr    <= '0;
                  slot_cnt    <= '0;
                  period_cnt  <= '0;
                  last_period <= P_SILENT;
                  locked      <= 1'b0;
               end
            end
            st_cap: begin
               // Gaps in availability simply freeze everything.
               if (consume) begin
                  slot_cnt    <= slot_cnt + 1'b1;
                  last_period <= last_next;
                  if (rise) begin
                     period_cnt <= '0;
                     locked     <= 1'b1;
                  end else begin
                     period_cnt <= period_inc;
                  end
                  // Final sample's update is folded into the write data.
                  if (slot_end) begin
                     state     <= WRITE;
                     mem_we    <= 1'b1;
                     mem_wdata <= last_next;
                  end
               end
            end
            st_wr: begin
               // Phase state (pol, locked, period_cnt) spans slots.
               last_period <= P_SILENT;
               slot_cnt    <= '0;
               if (mem_addr == A_LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  mem_addr <= mem_addr + 1'b1;
                  state    <= CAPTURE;
               end
            end
         endcase
      end
   end

endmodule
